// File: rtl/best_score_finder.sv
// Scans senone scores in SRAM for the largest signed 16-bit value and hands it,
// with a one-cycle start_norm pulse, to the downstream normaliser.
module best_score_finder #(
    parameter int n_senones = 10,
    parameter int base_addr = 0
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start_find,
    input  logic               sram_ready,
    output logic [20:0]        data_addr,
    output logic               read_data,
    output logic               write_data,
    output logic [15:0]        data_out,
    input  logic signed [15:0] data_in,
    output logic signed [15:0] best_score,
    output logic [7:0]         best_index,
    output logic               start_norm,
    input  logic               norm_done,
    output logic               busy
);

    typedef enum logic [1:0] {IDLE, READING, FINISH, WAIT_NORM} state_t;

    localparam logic [7:0]  LAST_INDEX = 8'(n_senones - 1);
    localparam logic [20:0] BASE_ADDR  = 21'(base_addr);

    state_t             r_state;
    state_t             w_state_next;
    logic [7:0]         r_senone_index;
    logic signed [15:0] r_best_score;
    logic [7:0]         r_best_index;
    logic               w_owns_bus;
    logic               w_take;
    logic               w_last;
    logic [20:0]        w_addr;

    // Index 0 always seeds the running maximum; strict compare keeps the lowest index on ties.
    assign w_take = (r_senone_index == 8'd0) || (data_in > r_best_score);
    assign w_last = (r_senone_index == LAST_INDEX);
    assign w_addr = BASE_ADDR + {12'd0, r_senone_index, 1'b0};

    always_comb begin
        w_state_next = r_state;
        w_owns_bus   = 1'b0;
        start_norm   = 1'b0;
        busy         = (r_state != IDLE);
        case (r_state)
            IDLE: begin
                if (start_find) w_state_next = READING;
            end
            READING: begin
                w_owns_bus = 1'b1;
                if (sram_ready && w_last) w_state_next = FINISH;
            end
            FINISH: begin
                start_norm   = 1'b1;
                w_state_next = WAIT_NORM;
            end
            WAIT_NORM: begin
                if (norm_done) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= IDLE;
            r_senone_index <= 8'd0;
            r_best_score   <= 16'sd0;
            r_best_index   <= 8'd0;
        end else begin
            r_state <= w_state_next;
            if (r_state == IDLE && start_find) begin
                r_senone_index <= 8'd0;
            end
            if (r_state == READING && sram_ready) begin
                if (w_take) begin
                    r_best_score <= data_in;
                    r_best_index <= r_senone_index;
                end
                if (!w_last) r_senone_index <= r_senone_index + 8'd1;
            end
        end
    end

    // The bus is shared with the normaliser, so it is released outside READING.
    assign data_addr  = w_owns_bus ? w_addr : 'z;
    assign read_data  = w_owns_bus ? 1'b1 : 1'bz;
    assign write_data = w_owns_bus ? 1'b0 : 1'bz;
    assign data_out   = 'z;
    assign best_score = r_best_score;
    assign best_index = r_best_index;

endmodule

// File: tb/tb_best_score_finder.sv
// Directed bench for best_score_finder: an SRAM model, a normaliser model that
// drives the shared bus when it owns it, and one task per scenario.
module tb_best_score_finder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               reset_n;
    logic               start_find;
    logic               sram_ready;
    logic               norm_done;
    logic               nm_own;
    wire  [20:0]        data_addr;
    wire                read_data;
    wire                write_data;
    wire  [15:0]        data_out;
    wire  signed [15:0] data_in;
    wire  signed [15:0] best_score;
    wire  [7:0]         best_index;
    wire                start_norm;
    wire                busy;

    localparam logic [20:0] NM_ADDR = 21'h15A5A;
    localparam logic [15:0] NM_DOUT = 16'hC3C3;

    // Normaliser model: drives a recognisable pattern whenever it owns the bus.
    assign data_addr  = nm_own ? NM_ADDR : 'z;
    assign read_data  = nm_own ? 1'b0 : 1'bz;
    assign write_data = nm_own ? 1'b1 : 1'bz;
    assign data_out   = nm_own ? NM_DOUT : 'z;

    logic signed [15:0] mem [16];
    assign data_in = mem[data_addr[4:1]];

    logic signed [15:0] scores_a [10] = '{16'sd5, -16'sd3, 16'sd100, 16'sd7, 16'sd100,
                                          16'sd0, -16'sd20, 16'sd1, 16'sd2, 16'sd3};
    logic signed [15:0] scores_b [10] = '{-16'sd500, -16'sd40, -16'sd32768, -16'sd41, -16'sd100,
                                          -16'sd200, -16'sd300, -16'sd32768, -16'sd1000, -16'sd41};

    best_score_finder #(.n_senones(10), .base_addr(0)) dut (
        .clk(clk), .reset_n(reset_n), .start_find(start_find), .sram_ready(sram_ready),
        .data_addr(data_addr), .read_data(read_data), .write_data(write_data),
        .data_out(data_out), .data_in(data_in), .best_score(best_score),
        .best_index(best_index), .start_norm(start_norm), .norm_done(norm_done), .busy(busy)
    );

    int total = 0;
    int bad   = 0;

    int          obs_lat;
    int          obs_pulses;
    int          obs_moved;
    int          obs_wr_bad;
    logic [20:0] obs_addrs [$];

    task automatic load_scores(input bit use_b);
        for (int i = 0; i < 16; i++) mem[i] = 16'sd0;
        for (int i = 0; i < 10; i++) mem[i] = use_b ? scores_b[i] : scores_a[i];
    endtask

    // Start a search and step until start_norm is seen (bounded); returns in the FINISH cycle.
    task automatic run_search(input int period, input int poke_cyc);
        bit          prev_wait = 1'b0;
        logic [20:0] prev_addr = '0;
        obs_addrs.delete();
        obs_lat = -1; obs_pulses = 0; obs_moved = 0; obs_wr_bad = 0;
        @(posedge clk); #1;
        nm_own = 1'b0; start_find = 1'b1; sram_ready = (period <= 1);
        for (int c = 1; c <= 200 && obs_lat < 0; c++) begin
            @(posedge clk); #1;
            start_find = (c == poke_cyc);
            sram_ready = (period <= 1) || (c % period == 0);
            @(negedge clk);
            if (start_norm === 1'b1) begin
                obs_pulses++;
                obs_lat = c;
            end
            if (read_data === 1'b1) begin
                if (write_data !== 1'b0) obs_wr_bad++;
                if (prev_wait && data_addr !== prev_addr) obs_moved++;
                if (sram_ready) obs_addrs.push_back(data_addr);
                prev_wait = !sram_ready;
                prev_addr = data_addr;
            end
        end
        start_find = 1'b0;
        $display("search: period=%0d latency=%0d reads=%0d best_score=%0d best_index=%0d",
                 period, obs_lat, obs_addrs.size(), best_score, best_index);
    endtask

    task automatic finish_norm();
        @(posedge clk); #1;
        nm_own = 1'b1; norm_done = 1'b1;
        @(posedge clk); #1;
        norm_done = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b1; start_find = 1'b0; sram_ready = 1'b1; norm_done = 1'b0; nm_own = 1'b1;
        load_scores(1'b0);
        #2 reset_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (start_norm !== 1'b0) begin bad++; $display("FAIL reset_start_norm: got %b want 0", start_norm); end
        total++; if (best_score !== 16'sd0) begin bad++; $display("FAIL reset_best_score: got %0d want 0", best_score); end
        total++; if (best_index !== 8'd0) begin bad++; $display("FAIL reset_best_index: got %0d want 0", best_index); end
        total++; if (data_addr !== NM_ADDR) begin bad++; $display("FAIL reset_bus_addr: got %h want %h", data_addr, NM_ADDR); end
        total++; if (read_data !== 1'b0 || write_data !== 1'b1) begin bad++; $display("FAIL reset_bus_strobes: got rd=%b wr=%b want rd=0 wr=1", read_data, write_data); end
        total++; if (data_out !== NM_DOUT) begin bad++; $display("FAIL reset_bus_dout: got %h want %h", data_out, NM_DOUT); end
        @(posedge clk); #1 reset_n = 1'b1;
    endtask

    task automatic test_basic();
        load_scores(1'b0);
        run_search(1, 0);
        total++; if (obs_lat !== 11) begin bad++; $display("FAIL basic_latency: got %0d want 11", obs_lat); end
        total++; if (best_score !== 16'sd100) begin bad++; $display("FAIL basic_best_score: got %0d want 100", best_score); end
        total++; if (best_index !== 8'd2) begin bad++; $display("FAIL basic_best_index: got %0d want 2", best_index); end
        total++; if (obs_wr_bad !== 0) begin bad++; $display("FAIL basic_write_strobe: got %0d bad cycles want 0", obs_wr_bad); end
        total++; if (obs_addrs.size() !== 10) begin bad++; $display("FAIL basic_read_count: got %0d want 10", obs_addrs.size()); end
        for (int i = 0; i < 10; i++) begin
            total++;
            if (obs_addrs.size() <= i || obs_addrs[i] !== 21'(2 * i)) begin
                bad++; $display("FAIL basic_addr[%0d]: got %h want %h", i, (obs_addrs.size() > i) ? obs_addrs[i] : 21'h0, 21'(2 * i));
            end
        end
        @(posedge clk); #1 nm_own = 1'b1;
        @(negedge clk);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL wait_busy: got %b want 1", busy); end
        total++; if (start_norm !== 1'b0) begin bad++; $display("FAIL wait_start_norm: got %b want 0", start_norm); end
        total++; if (data_addr !== NM_ADDR || data_out !== NM_DOUT) begin bad++; $display("FAIL wait_bus_data: got addr=%h dout=%h want addr=%h dout=%h", data_addr, data_out, NM_ADDR, NM_DOUT); end
        total++; if (read_data !== 1'b0 || write_data !== 1'b1) begin bad++; $display("FAIL wait_bus_strobes: got rd=%b wr=%b want rd=0 wr=1", read_data, write_data); end
        norm_done = 1'b1;
        @(posedge clk); #1 norm_done = 1'b0;
        @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_release: got busy=%b want 0", busy); end
    endtask

    task automatic test_negative();
        load_scores(1'b1);
        run_search(1, 0);
        total++; if (best_score !== -16'sd40) begin bad++; $display("FAIL neg_best_score: got %0d want -40", best_score); end
        total++; if (best_index !== 8'd1) begin bad++; $display("FAIL neg_best_index: got %0d want 1", best_index); end
        finish_norm();
    endtask

    task automatic test_ready_toggle();
        load_scores(1'b0);
        run_search(3, 0);
        total++; if (obs_lat !== 31) begin bad++; $display("FAIL toggle_latency: got %0d want 31", obs_lat); end
        total++; if (best_score !== 16'sd100 || best_index !== 8'd2) begin bad++; $display("FAIL toggle_result: got %0d@%0d want 100@2", best_score, best_index); end
        total++; if (obs_moved !== 0) begin bad++; $display("FAIL toggle_addr_hold: got %0d moves want 0", obs_moved); end
        total++; if (obs_addrs.size() !== 10) begin bad++; $display("FAIL toggle_read_count: got %0d want 10", obs_addrs.size()); end
        for (int i = 0; i < 10; i++) begin
            total++;
            if (obs_addrs.size() <= i || obs_addrs[i] !== 21'(2 * i)) begin
                bad++; $display("FAIL toggle_addr[%0d]: got %h want %h", i, (obs_addrs.size() > i) ? obs_addrs[i] : 21'h0, 21'(2 * i));
            end
        end
        finish_norm();
    endtask

    task automatic test_ignore_start();
        int pulses = 0;
        int busy_low = 0;
        load_scores(1'b0);
        run_search(1, 5);
        total++; if (obs_lat !== 11 || obs_pulses !== 1) begin bad++; $display("FAIL ignore_in_reading: got lat=%0d pulses=%0d want 11/1", obs_lat, obs_pulses); end
        // norm_done during FINISH must be ignored; start_find in WAIT_NORM must not queue.
        norm_done = 1'b1;
        @(posedge clk); #1;
        norm_done = 1'b0; start_find = 1'b1; nm_own = 1'b1;
        @(posedge clk); #1 start_find = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (start_norm === 1'b1) pulses++;
            if (busy !== 1'b1) busy_low++;
        end
        total++; if (pulses !== 0) begin bad++; $display("FAIL ignore_in_wait_pulses: got %0d want 0", pulses); end
        total++; if (busy_low !== 0) begin bad++; $display("FAIL ignore_finish_norm_done: got %0d idle cycles want 0", busy_low); end
        finish_norm();
        pulses = 0; busy_low = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (start_norm === 1'b1) pulses++;
            if (busy !== 1'b0) busy_low++;
        end
        total++; if (pulses !== 0 || busy_low !== 0) begin bad++; $display("FAIL ignore_not_queued: got pulses=%0d busy_cycles=%0d want 0/0", pulses, busy_low); end
        load_scores(1'b1);
        run_search(1, 0);
        total++; if (best_score !== -16'sd40 || best_index !== 8'd1) begin bad++; $display("FAIL ignore_new_search: got %0d@%0d want -40@1", best_score, best_index); end
        finish_norm();
    endtask

    task automatic test_reset_mid();
        int pulses = 0;
        load_scores(1'b0);
        @(posedge clk); #1;
        nm_own = 1'b0; start_find = 1'b1; sram_ready = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(posedge clk); #1 start_find = 1'b0;
        end
        @(negedge clk);
        total++; if (data_addr !== 21'd8) begin bad++; $display("FAIL mid_addr_before_reset: got %h want 8", data_addr); end
        reset_n = 1'b0; nm_own = 1'b1;
        #1;
        total++; if (data_addr !== NM_ADDR || read_data !== 1'b0 || write_data !== 1'b1) begin bad++; $display("FAIL mid_bus_release: got addr=%h rd=%b wr=%b want addr=%h rd=0 wr=1", data_addr, read_data, write_data, NM_ADDR); end
        total++; if (best_score !== 16'sd0 || best_index !== 8'd0) begin bad++; $display("FAIL mid_reset_best: got %0d@%0d want 0@0", best_score, best_index); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_reset_busy: got %b want 0", busy); end
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (start_norm === 1'b1) pulses++;
        end
        total++; if (pulses !== 0) begin bad++; $display("FAIL mid_no_start_norm: got %0d pulses want 0", pulses); end
        @(posedge clk); #1 reset_n = 1'b1;
        load_scores(1'b1);
        run_search(1, 0);
        total++; if (obs_lat !== 11 || best_score !== -16'sd40 || best_index !== 8'd1) begin bad++; $display("FAIL mid_recover: got lat=%0d %0d@%0d want 11 -40@1", obs_lat, best_score, best_index); end
        finish_norm();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_negative();
        test_ready_toggle();
        test_ignore_start();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/best_score_finder.md
Name: best_score_finder

Overview:
- Scans the n_senones senone scores held in SRAM and finds the best one, which is the maximum signed 16-bit value.
- Hands the best score and a one-cycle start_norm pulse to the normaliser directly downstream.
- Holds off new searches until the normaliser reports norm_done.
- Shares the SRAM bus with the normaliser; all bus outputs are high-Z when this block does not own the bus.

Parameters:
n_senones, 10, number of senone scores to scan (1..256)
base_addr, 0, SRAM word address of senone 0; senone i lives at base_addr + (i<<1)

Ports:
clk  input  1  system clock, all state on rising edge
reset_n  input  1  asynchronous, active-low reset
start_find  input  1  request a search; sampled only in IDLE
sram_ready  input  1  SRAM has completed the current access; data_in valid this cycle
data_addr  output  21  SRAM address; Z when bus not owned
read_data  output  1  SRAM read strobe; 1 in READING, Z otherwise
write_data  output  1  SRAM write strobe; 0 in READING, Z otherwise (never writes)
data_out  output  16  SRAM write data; always Z
data_in  input  16  SRAM read data, signed (num)
best_score  output  16  signed maximum found; stable from start_norm until next search starts
best_index  output  8  index of best_score
start_norm  output  1  one-cycle pulse to normaliser: best_score valid
norm_done  input  1  normaliser finished; releases this block
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (reset_n low, asynchronous):
  - state=IDLE; senone_index=0; best_score=0; best_index=0; start_norm=0.
  - Bus outputs are Z immediately.
- Reset mid-operation aborts the scan; no start_norm is emitted.
- States: IDLE, READING, FINISH, WAIT_NORM.
- IDLE:
  - Bus is Z.
  - On start_find=1: senone_index<=0, go to READING.
  - start_find in any other state is ignored (not queued).
- READING:
  - data_addr = base_addr + (senone_index<<1), zero-extended to 21 bits.
  - read_data=1; write_data=0.
  - Waits indefinitely while sram_ready=0.
  - On sram_ready=1:
    - If senone_index==0, or signed data_in > best_score: best_score<=data_in, best_index<=senone_index.
    - Comparison is strict, so ties keep the lowest index.
    - If senone_index==n_senones-1, go to FINISH; else senone_index+1 and stay in READING.
  - With sram_ready held high, each senone takes 1 cycle.
- FINISH:
  - Bus is Z.
  - start_norm=1 for exactly this one cycle; go to WAIT_NORM.
- WAIT_NORM:
  - Bus is Z; best_score and best_index are held.
  - On norm_done=1, go to IDLE.
  - norm_done arriving in the same cycle as FINISH is not observed; only norm_done seen in WAIT_NORM counts.
- Latency:
  - start_find sampled → first read address: 1 cycle.
  - Last sram_ready → start_norm: 1 cycle.
  - With sram_ready always high, start_norm asserts n_senones+1 cycles after the start_find edge.
- Arithmetic:
  - Pure signed 16-bit compare; no saturation.
  - -32768 is a valid score.
  - The first score always seeds best_score regardless of its value, including all-negative inputs.
- n_senones=1: a single read, then FINISH.

Test Plan:
- Scores [5,-3,100,7,100,0,-20,1,2,3], sram_ready always 1, start_find pulse → start_norm 11 cycles later; best_score=100; best_index=2 (tie keeps first); busy high until norm_done.
- All-negative scores [-500,-40,-32768,-41,...] → best_score=-40, best_index=1; confirms seeding from index 0, not from reset value 0.
- sram_ready toggling 1-of-3 cycles → same result as the fixed-ready run; data_addr holds steady while waiting; addresses 0,2,4,…,18 each read exactly once.
- start_find pulsed during READING and again during WAIT_NORM → ignored; only one start_norm pulse; a new search starts only after norm_done then start_find.
- reset_n driven low at senone 4 → bus Z in the same cycle (asynchronous); best_score=0; no start_norm; after release, a new start_find completes normally.
- Bus ownership: in IDLE and WAIT_NORM, data_addr/read_data/write_data/data_out all Z; a normaliser model driving the bus then causes no X contention.
